// File: rtl/matrix_alu_seq.sv
// Sequential matrix ALU: one element (or one MAC) per cycle through a shared datapath,
// with wrap/saturate selectable at elaboration and a sticky per-operation overflow flag.
module matrix_alu_seq #(
    parameter int N        = 5,
    parameter int W        = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op_code,
    input  logic [N*N*W-1:0] matrix_a,
    input  logic [N*N*W-1:0] matrix_b,
    input  logic [W-1:0]     scalar,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             op_error,
    output logic [N*N*W-1:0] result
);
    localparam int CW = $clog2(N);
    localparam int AW = 2*W + $clog2(N);
    localparam logic [CW-1:0]        LAST = CW'(N-1);
    localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, EXEC, MAC, DONE} state_t;

    state_t               state_q, state_d;
    logic [N*N*W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic [W-1:0]         s_q, s_d;
    logic [2:0]           op_q, op_d;
    logic [CW-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, err_q, err_d;

    logic signed [AW-1:0] xa_ij, xb_ij, xa_ji, xa_ik, xb_kj, xs;
    logic signed [AW-1:0] ew, prod, mac_sum, wv;
    logic                 wr;

    function automatic logic signed [AW-1:0] elem(input logic [N*N*W-1:0] m,
                                                   input logic [CW-1:0] r,
                                                   input logic [CW-1:0] c);
        logic [W-1:0] x;
        x = m[(int'(r)*N + int'(c))*W +: W];
        return {{(AW-W){x[W-1]}}, x};
    endfunction

    function automatic logic in_range(input logic signed [AW-1:0] v);
        return (v <= MAXV) && (v >= MINV);
    endfunction

    function automatic logic [W-1:0] fit(input logic signed [AW-1:0] v);
        if (SATURATE != 0 && v > MAXV) return MAXV[W-1:0];
        if (SATURATE != 0 && v < MINV) return MINV[W-1:0];
        return v[W-1:0];
    endfunction

    always_comb begin
        xa_ij   = elem(a_q, i_q, j_q);
        xb_ij   = elem(b_q, i_q, j_q);
        xa_ji   = elem(a_q, j_q, i_q);
        xa_ik   = elem(a_q, i_q, k_q);
        xb_kj   = elem(b_q, k_q, j_q);
        xs      = {{(AW-W){s_q[W-1]}}, s_q};
        prod    = xa_ik * xb_kj;
        mac_sum = (k_q == '0) ? prod : acc_q + prod;
        case (op_q)
            3'b000:  ew = xa_ij + xb_ij;
            3'b001:  ew = xa_ij - xb_ij;
            3'b010:  ew = xa_ji;
            3'b011:  ew = -xa_ij;
            3'b100:  ew = xs * xa_ij;
            default: ew = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        op_d    = op_q;
        res_d   = res_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        err_d   = err_q;
        wr      = 1'b0;
        wv      = '0;
        case (state_q)
            IDLE: begin
                // The done cycle itself still counts as part of the finishing op.
                if (start && !done_q) begin
                    a_d    = matrix_a;
                    b_d    = matrix_b;
                    s_d    = scalar;
                    op_d   = op_code;
                    res_d  = '0;
                    ovf_d  = 1'b0;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    i_d    = '0;
                    j_d    = '0;
                    k_d    = '0;
                    acc_d  = '0;
                    case (op_code)
                        3'b000, 3'b001, 3'b010, 3'b011, 3'b100: state_d = EXEC;
                        3'b110:  state_d = MAC;
                        default: begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            EXEC: begin
                wr  = 1'b1;
                wv  = ew;
                j_d = j_q + 1'b1;
                if (j_q == LAST) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                    if (i_q == LAST) state_d = DONE;
                end
            end
            MAC: begin
                acc_d = mac_sum;
                k_d   = k_q + 1'b1;
                if (k_q == LAST) begin
                    wr    = 1'b1;
                    wv    = mac_sum;
                    acc_d = '0;
                    k_d   = '0;
                    j_d   = j_q + 1'b1;
                    if (j_q == LAST) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                        if (i_q == LAST) state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (wr) begin
            res_d[(int'(i_q)*N + int'(j_q))*W +: W] = fit(wv);
            if (!in_range(wv)) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            op_q    <= op_d;
            res_q   <= res_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign op_error = err_q;
    assign result   = res_q;
endmodule

// File: tb/tb_matrix_alu_seq.sv
// Bench for matrix_alu_seq: wrap and saturate 2x2 instances share one vector table,
// and a default 5x5 instance covers the abort-by-reset sequence.
module tb_matrix_alu_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start2;
    logic [2:0]  op2;
    logic [31:0] a2, b2;
    logic [7:0]  s2;
    logic        busy_w, done_w, ovf_w, err_w, busy_s, done_s, ovf_s, err_s;
    logic [31:0] res_w, res_s;

    logic         rst5, start5;
    logic [2:0]   op5;
    logic [199:0] a5, b5, res5, exp5;
    logic [7:0]   s5;
    logic         busy5, done5, ovf5, err5;

    matrix_alu_seq #(.N(2), .W(8), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst_n), .start(start2), .op_code(op2), .matrix_a(a2), .matrix_b(b2),
        .scalar(s2), .busy(busy_w), .done(done_w), .overflow(ovf_w), .op_error(err_w), .result(res_w));
    matrix_alu_seq #(.N(2), .W(8), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst_n), .start(start2), .op_code(op2), .matrix_a(a2), .matrix_b(b2),
        .scalar(s2), .busy(busy_s), .done(done_s), .overflow(ovf_s), .op_error(err_s), .result(res_s));
    matrix_alu_seq #(.N(5), .W(8), .SATURATE(0)) u_n5 (
        .clk(clk), .rst(rst5), .start(start5), .op_code(op5), .matrix_a(a5), .matrix_b(b5),
        .scalar(s5), .busy(busy5), .done(done5), .overflow(ovf5), .op_error(err5), .result(res5));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [7:0]  s;
        logic [31:0] rw, rs;
        logic        ov, er;
        int          lat, p1, p2;
    } vec_t;

    typedef struct {
        logic [31:0] rw, rs;
        logic        ov, er;
        int          lat;
    } exp_t;

    vec_t tv[11];
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] pk(input int x0, input int x1, input int x2, input int x3);
        return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int s, input logic [31:0] rw, input logic [31:0] rs, input logic ov,
                        input logic er, input int lat, input int p1, input int p2);
        tv[i].op = op; tv[i].a = a; tv[i].b = b; tv[i].s = 8'(s);
        tv[i].rw = rw; tv[i].rs = rs; tv[i].ov = ov; tv[i].er = er;
        tv[i].lat = lat; tv[i].p1 = p1; tv[i].p2 = p2;
    endtask

    task automatic run_vec(input int v);
        exp_t e;
        int   n;
        logic got, busy_ok;
        @(negedge clk);
        op2 = tv[v].op; a2 = tv[v].a; b2 = tv[v].b; s2 = tv[v].s; start2 = 1'b1;
        @(posedge clk);
        e.rw = tv[v].rw; e.rs = tv[v].rs; e.ov = tv[v].ov; e.er = tv[v].er; e.lat = tv[v].lat;
        sbq.push_back(e);
        #1;
        // Scrambled operands after acceptance must not matter.
        a2 = $urandom; b2 = $urandom; s2 = 8'($urandom); op2 = 3'($urandom);
        n = 0; got = 1'b0; busy_ok = 1'b1;
        while (n < 100 && !got) begin
            start2 = (n + 1 == tv[v].p1) || (n + 1 == tv[v].p2);
            @(posedge clk);
            n++;
            #1;
            if (done_w) got = 1'b1;
            else if (!busy_w || !busy_s) busy_ok = 1'b0;
        end
        start2 = 1'b0;
        e = sbq.pop_front();
        check($sformatf("v%0d latency", v), n, e.lat);
        check($sformatf("v%0d busy_during_op", v), busy_ok, 1'b1);
        check($sformatf("v%0d done_sat", v), done_s, 1'b1);
        check($sformatf("v%0d busy_in_done", v), {busy_w, busy_s}, 2'b00);
        check($sformatf("v%0d result_wrap", v), res_w, e.rw);
        check($sformatf("v%0d result_sat", v), res_s, e.rs);
        check($sformatf("v%0d overflow", v), {ovf_w, ovf_s}, {e.ov, e.ov});
        check($sformatf("v%0d op_error", v), {err_w, err_s}, {e.er, e.er});
        @(posedge clk);
        #1;
        check($sformatf("v%0d done_one_cycle", v), {done_w, done_s}, 2'b00);
        if (tv[v].p2 > 0) begin
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d late_start_ignored", v), {busy_w, done_w, res_w}, {2'b00, e.rw});
        end
    endtask

    initial begin
        int   n;
        logic seen;
        rst_n = 1'b0; rst5 = 1'b0; start2 = 1'b0; start5 = 1'b0;
        op2 = '0; a2 = '0; b2 = '0; s2 = '0; op5 = '0; a5 = '0; b5 = '0; s5 = '0;

        setv(0,  3'b000, pk(1,2,3,4),       pk(10,20,30,40), 0,  pk(11,22,33,44), pk(11,22,33,44), 0, 0, 5, -1, -1);
        setv(1,  3'b000, pk(100,0,0,0),     pk(100,0,0,0),   0,  pk(-56,0,0,0),   pk(127,0,0,0),   1, 0, 5, -1, -1);
        setv(2,  3'b110, pk(1,2,3,4),       pk(5,6,7,8),     0,  pk(19,22,43,50), pk(19,22,43,50), 0, 0, 9, 3, 9);
        setv(3,  3'b011, pk(0,0,0,-128),    pk(0,0,0,0),     0,  pk(0,0,0,-128),  pk(0,0,0,127),   1, 0, 5, -1, -1);
        setv(4,  3'b010, pk(1,2,3,4),       pk(0,0,0,0),     0,  pk(1,3,2,4),     pk(1,3,2,4),     0, 0, 5, -1, -1);
        setv(5,  3'b101, pk(1,2,3,4),       pk(5,6,7,8),     0,  pk(0,0,0,0),     pk(0,0,0,0),     0, 1, 1, -1, -1);
        setv(6,  3'b100, pk(1,-2,3,50),     pk(0,0,0,0),     -3, pk(-3,6,-9,106), pk(-3,6,-9,-128), 1, 0, 5, -1, -1);
        setv(7,  3'b001, pk(-100,5,0,127),  pk(100,-3,0,-1), 0,  pk(56,8,0,-128), pk(-128,8,0,127), 1, 0, 5, -1, -1);
        setv(8,  3'b110, pk(100,100,0,0),   pk(100,0,100,0), 0,  pk(32,0,0,0),    pk(127,0,0,0),   1, 0, 9, -1, -1);
        setv(9,  3'b111, pk(1,2,3,4),       pk(5,6,7,8),     0,  pk(0,0,0,0),     pk(0,0,0,0),     0, 1, 1, -1, -1);
        setv(10, 3'b110, pk(-1,2,-3,4),     pk(5,-6,7,-8),   0,  pk(9,-10,13,-14), pk(9,-10,13,-14), 0, 0, 9, -1, -1);

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                a5[(i*5+j)*8 +: 8] = 8'(((i*5 + j) % 7) - 3);
                b5[(i*5+j)*8 +: 8] = 8'(((i + 2*j) % 5) - 2);
            end
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < 5; k++)
                    acc += int'($signed(a5[(i*5+k)*8 +: 8])) * int'($signed(b5[(k*5+j)*8 +: 8]));
                exp5[(i*5+j)*8 +: 8] = 8'(acc);
            end

        repeat (2) @(negedge clk);
        check("reset_wrap", {busy_w, done_w, ovf_w, err_w, res_w}, '0);
        check("reset_sat",  {busy_s, done_s, ovf_s, err_s, res_s}, '0);
        check("reset_n5",   {busy5, done5, ovf5, err5, res5}, '0);
        rst_n = 1'b1; rst5 = 1'b1;

        for (int v = 0; v < 11; v++) run_vec(v);

        // 5x5 matrix multiply aborted by reset mid-operation.
        @(negedge clk);
        op5 = 3'b110; start5 = 1'b1;
        @(posedge clk);
        #1 start5 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("n5_busy_before_abort", {busy5, done5}, 2'b10);
        rst5 = 1'b0;
        #1;
        check("n5_async_reset", {busy5, done5, ovf5, err5, res5}, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst5 = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done5 || busy5) seen = 1'b1;
        end
        check("n5_no_done_after_abort", seen, 1'b0);

        @(negedge clk);
        start5 = 1'b1;
        @(posedge clk);
        #1 start5 = 1'b0;
        op5 = 3'b000; a5 = '0;
        n = 0;
        while (n < 300 && !done5) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("n5_latency", n, 126);
        check("n5_result", res5, exp5);
        check("n5_flags", {ovf5, err5}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
